// File: rtl/muldiv_alu_control_pkg.sv
// rtl/muldiv_alu_control_pkg.sv - shared opcode/funct, ALU op and sequencer state encodings
//
// Purpose: common header for the decode/execute boundary. It holds the
// instruction field encodings, the 4-bit ALU op codes and the state
// encoding of the multiply/divide sequencer.
package muldiv_alu_control_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // ALU operation codes
  localparam logic [3:0] ALU_add     = 4'd1;
  localparam logic [3:0] ALU_sub     = 4'd2;
  localparam logic [3:0] ALU_sra     = 4'd3;
  localparam logic [3:0] ALU_sll     = 4'd4;
  localparam logic [3:0] ALU_OR      = 4'd5;
  localparam logic [3:0] ALU_slli    = 4'd6;
  localparam logic [3:0] ALU_rs_pass = 4'd7;
  localparam logic [3:0] ALU_undef   = 4'hF;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring divide
//
// Purpose: combinational single-step datapath for the iterative sequencer.
// Ports:
//   div_mode  in  1    : 1 = restoring shift-subtract, 0 = shift-add
//   acc       in  2W   : multiply {partial, multiplier}; divide {remainder, quotient}
//   b         in  W    : multiplicand (multiply) or divisor (divide)
//   acc_nxt   out 2W   : accumulator after this step
module muldiv_step #(
  parameter int W = 32
) (
  input  logic             div_mode,
  input  logic [2*W-1:0]   acc,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   acc_nxt
);

  logic [W:0] add_sum;
  logic [W:0] rem_sh;
  logic [W:0] rem_diff;
  logic       rem_ge;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : '0);
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The remainder stays below b, so a non-negative difference is below 2^W
    // and the top bit of the W+1-bit difference is a clean borrow flag.
    rem_sh   = acc[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, b};
    rem_ge   = ~rem_diff[W];
    if (div_mode) begin
      if (rem_ge) acc_nxt = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
      else        acc_nxt = {rem_sh[W-1:0],   acc[W-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_alu_control.sv
// rtl/muldiv_alu_control.sv - ALU op decoder with iterative multiply/divide and HI/LO
//
// Purpose: decodes opcode/funct to the ALU op and runs MULT/MULTU/DIV/DIVU
// over W+1 cycles on a shared shift datapath, holding the pipeline with stall.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_in, flush   : instruction valid in EX / kill the presented instruction
//   opcode, funct     : instruction fields
//   rs_val, rt_val    : operands (rs also feeds MTHI/MTLO)
//   alu_op            : decoded ALU operation (combinational)
//   stall             : front-end hold (combinational)
//   busy              : sequencer not idle
//   hilo_rd           : HI for MFHI, LO for MFLO, else 0
//   hi, lo            : architectural HI/LO registers
module muldiv_alu_control
  import muldiv_alu_control_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic         flush,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic [3:0]   alu_op,
  output logic         stall,
  output logic         busy,
  output logic [W-1:0] hilo_rd,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_step;
  logic [W-1:0]     b_reg;
  logic             neg_q;   // product / quotient negation
  logic             neg_r;   // remainder negation (dividend sign)
  logic             op_div;  // latched op kind: divide
  logic             dz;      // latched divide-by-zero

  // Instruction classification
  logic is_rtype, is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic md_op, md_class, div_op, signed_op, rt_zero;
  logic fire, start, last_step;
  logic [W-1:0] rs_mag, rt_mag;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_mult   = is_rtype & (funct == FN_MULT);
  assign is_multu  = is_rtype & (funct == FN_MULTU);
  assign is_div    = is_rtype & (funct == FN_DIV);
  assign is_divu   = is_rtype & (funct == FN_DIVU);
  assign is_mfhi   = is_rtype & (funct == FN_MFHI);
  assign is_mflo   = is_rtype & (funct == FN_MFLO);
  assign is_mthi   = is_rtype & (funct == FN_MTHI);
  assign is_mtlo   = is_rtype & (funct == FN_MTLO);

  assign md_op     = is_mult | is_multu | is_div | is_divu;
  assign md_class  = md_op | is_mfhi | is_mflo | is_mthi | is_mtlo;
  assign div_op    = is_div | is_divu;
  assign signed_op = is_mult | is_div;
  assign rt_zero   = (rt_val == '0);

  assign busy      = (state != MD_IDLE);
  assign stall     = valid_in & busy & md_class;
  assign fire      = valid_in & ~flush & ~stall;
  assign start     = fire & md_op;
  assign last_step = (cnt == CNT_W'(W - 1));

  // Magnitudes for signed ops; MIN maps to itself, which is its correct
  // unsigned magnitude.
  assign rs_mag = (signed_op & rs_val[W-1]) ? -rs_val : rs_val;
  assign rt_mag = (signed_op & rt_val[W-1]) ? -rt_val : rt_val;

  assign hilo_rd = is_mfhi ? hi : (is_mflo ? lo : '0);

  // ALU op decode
  always_comb begin
    alu_op = ALU_undef;
    if (is_rtype) begin
      case (funct)
        FN_ADD, FN_ADDU:                      alu_op = ALU_add;
        FN_SUBU:                              alu_op = ALU_sub;
        FN_SRA:                               alu_op = ALU_sra;
        FN_SLL:                               alu_op = ALU_sll;
        FN_SYSCALL, FN_JR:                    alu_op = 4'd0;
        FN_MFHI, FN_MFLO:                     alu_op = ALU_rs_pass;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
        FN_MTHI, FN_MTLO:                     alu_op = 4'd0;
        default:                              alu_op = ALU_undef;
      endcase
    end else begin
      case (opcode)
        OP_SW, OP_SB, OP_LW, OP_ADDIU:        alu_op = ALU_add;
        OP_ORI:                               alu_op = ALU_OR;
        OP_LUI:                               alu_op = ALU_slli;
        default:                              alu_op = ALU_undef;
      endcase
    end
  end

  muldiv_step #(.W(W)) u_step (
    .div_mode (state == MD_DIV),
    .acc      (acc),
    .b        (b_reg),
    .acc_nxt  (acc_step)
  );

  // Sign fix-up applied in FIX
  logic [2*W-1:0] fix_prod;
  logic [W-1:0]   fix_q, fix_r;
  assign fix_prod = neg_q ? -acc : acc;
  assign fix_q    = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign fix_r    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: begin
        if (start) begin
          if (!div_op)      state_nxt = MD_MUL;
          else if (rt_zero) state_nxt = MD_FIX;
          else              state_nxt = MD_DIV;
        end
      end
      MD_MUL, MD_DIV: if (last_step) state_nxt = MD_FIX;
      MD_FIX:         state_nxt = MD_IDLE;
      default:        state_nxt = MD_IDLE;
    endcase
  end

  // Datapath, counter and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      b_reg  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      op_div <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt    <= '0;
            op_div <= div_op;
            dz     <= div_op & rt_zero;
            neg_q  <= signed_op & (rs_val[W-1] ^ rt_val[W-1]);
            neg_r  <= signed_op & rs_val[W-1];
            if (div_op && rt_zero) begin
              // Divide-by-zero result is staged directly in the accumulator.
              acc   <= {rs_val, {W{1'b1}}};
              b_reg <= '0;
            end else if (div_op) begin
              acc   <= {{W{1'b0}}, rs_mag};
              b_reg <= rt_mag;
            end else begin
              acc   <= {{W{1'b0}}, rt_mag};
              b_reg <= rs_mag;
            end
          end else if (fire && is_mthi) begin
            hi <= rs_val;
          end else if (fire && is_mtlo) begin
            lo <= rs_val;
          end
        end
        MD_MUL, MD_DIV: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        MD_FIX: begin
          if (dz) begin
            hi <= acc[2*W-1:W];
            lo <= acc[W-1:0];
          end else if (op_div) begin
            hi <= fix_r;
            lo <= fix_q;
          end else begin
            hi <= fix_prod[2*W-1:W];
            lo <= fix_prod[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_alu_control.sv
// tb/tb_muldiv_alu_control.sv - self-checking bench for muldiv_alu_control
module tb_muldiv_alu_control;
  import muldiv_alu_control_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   opcode = 6'h0;
  logic [5:0]   funct = 6'h0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic [3:0]   alu_op;
  logic         stall;
  logic         busy;
  logic [W-1:0] hilo_rd;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_alu_control #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .flush    (flush),
    .opcode   (opcode),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_op   (alu_op),
    .stall    (stall),
    .busy     (busy),
    .hilo_rd  (hilo_rd),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    longint       sa, sb, sq, sr;
    logic [63:0]  ua, ub, uq, ur, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = 64'h0;
    case (fn)
      FN_MULT:  begin sq = sa * sb; p = sq; end
      FN_MULTU: p = ua * ub;
      FN_DIV: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      FN_DIVU: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          p  = {ur[31:0], uq[31:0]};
        end
      end
      default: p = 64'h0;
    endcase
    return p;
  endfunction

  function automatic int exp_busy(input logic [5:0] fn, input logic [31:0] b);
    if ((fn == FN_DIV || fn == FN_DIVU) && b == 32'h0) return 1;
    return W + 1;
  endfunction

  // Issue one multiply/divide, wait for completion, check busy length and HI/LO.
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input bit flush_next);
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    valid_in = 1'b1; opcode = OP_RTYPE; funct = fn; rs_val = a; rt_val = b;
    @(negedge clk);
    valid_in = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      flush = flush_next && (cyc == 0);
      cyc++;
      @(negedge clk);
    end
    flush = 1'b0;
    e = ref_hilo(fn, a, b);
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_busy(fn, b)));
    check({tag, " hi"}, {32'h0, hi}, {32'h0, e[63:32]});
    check({tag, " lo"}, {32'h0, lo}, {32'h0, e[31:0]});
  endtask

  task automatic chk_dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] e);
    opcode = op; funct = fn;
    #1;
    check({tag, " alu_op"}, {60'h0, alu_op}, {60'h0, e});
  endtask

  initial begin
    int cyc;
    logic [5:0]  fn;
    logic [31:0] a, b, x;
    logic [63:0] e;
    logic [31:0] hi_s, lo_s;
    logic [5:0]  fns [4];

    fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;

    // Reset state
    #1;
    check("reset hi", {32'h0, hi}, 64'h0);
    check("reset lo", {32'h0, lo}, 64'h0);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset stall", {63'h0, stall}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table
    chk_dec("ADD",     OP_RTYPE, FN_ADD,     ALU_add);
    chk_dec("ADDU",    OP_RTYPE, FN_ADDU,    ALU_add);
    chk_dec("SW",      OP_SW,    6'h15,      ALU_add);
    chk_dec("SB",      OP_SB,    6'h00,      ALU_add);
    chk_dec("LW",      OP_LW,    6'h3F,      ALU_add);
    chk_dec("ADDIU",   OP_ADDIU, 6'h12,      ALU_add);
    chk_dec("SUBU",    OP_RTYPE, FN_SUBU,    ALU_sub);
    chk_dec("SRA",     OP_RTYPE, FN_SRA,     ALU_sra);
    chk_dec("SLL",     OP_RTYPE, FN_SLL,     ALU_sll);
    chk_dec("ORI",     OP_ORI,   6'h00,      ALU_OR);
    chk_dec("LUI",     OP_LUI,   6'h00,      ALU_slli);
    chk_dec("SYSCALL", OP_RTYPE, FN_SYSCALL, 4'd0);
    chk_dec("JR",      OP_RTYPE, FN_JR,      4'd0);
    chk_dec("MFHI",    OP_RTYPE, FN_MFHI,    ALU_rs_pass);
    chk_dec("MFLO",    OP_RTYPE, FN_MFLO,    ALU_rs_pass);
    chk_dec("MULT",    OP_RTYPE, FN_MULT,    4'd0);
    chk_dec("MULTU",   OP_RTYPE, FN_MULTU,   4'd0);
    chk_dec("DIV",     OP_RTYPE, FN_DIV,     4'd0);
    chk_dec("DIVU",    OP_RTYPE, FN_DIVU,    4'd0);
    chk_dec("MTHI",    OP_RTYPE, FN_MTHI,    4'd0);
    chk_dec("MTLO",    OP_RTYPE, FN_MTLO,    4'd0);
    chk_dec("SLT",     OP_RTYPE, 6'h2A,      ALU_undef);
    chk_dec("BEQ",     6'h04,    6'h00,      ALU_undef);

    // Directed multiply/divide cases
    run_md("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0);
    run_md("mult_neg",  FN_MULT,  32'hFFFFFFFD, 32'h5, 1'b0);
    run_md("div_neg",   FN_DIV,   32'hFFFFFFF9, 32'h2, 1'b0);
    run_md("div_ovf",   FN_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_md("divu_zero", FN_DIVU,  32'h00001234, 32'h0, 1'b0);
    run_md("div_zero",  FN_DIV,   32'h80000005, 32'h0, 1'b0);
    check("div_zero hilo_rd idle", {32'h0, hilo_rd}, 64'h0);

    // MFLO stalls behind DIV; independent ADDU does not.
    @(negedge clk);
    valid_in = 1'b1; opcode = OP_RTYPE; funct = FN_DIV; rs_val = 32'd100; rt_val = 32'hFFFFFFF9;
    @(negedge clk);
    funct = FN_ADDU;
    #1;
    check("addu_in_window stall", {63'h0, stall}, 64'h0);
    check("addu_in_window alu_op", {60'h0, alu_op}, {60'h0, ALU_add});
    @(negedge clk);
    funct = FN_MFLO;
    #1;
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    e = ref_hilo(FN_DIV, 32'd100, 32'hFFFFFFF9);
    check("mflo stall_cycles", 64'(cyc), 64'(W));
    check("mflo hilo_rd", {32'h0, hilo_rd}, {32'h0, e[31:0]});
    funct = FN_MFHI;
    #1;
    check("mfhi hilo_rd", {32'h0, hilo_rd}, {32'h0, e[63:32]});
    valid_in = 1'b0;

    // Flush in the start cycle suppresses the start.
    hi_s = hi; lo_s = lo;
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b1; opcode = OP_RTYPE; funct = FN_MULT; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    check("flush_start busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check("flush_start hi", {32'h0, hi}, {32'h0, hi_s});
    check("flush_start lo", {32'h0, lo}, {32'h0, lo_s});

    // Flush after start does not abort.
    run_md("mult_flush", FN_MULT, 32'h00012345, 32'hFFFF0003, 1'b1);

    // MTHI / MTLO while idle
    @(negedge clk);
    valid_in = 1'b1; opcode = OP_RTYPE; funct = FN_MTHI; rs_val = 32'hA5A5A5A5;
    @(negedge clk);
    valid_in = 1'b0;
    check("mthi_idle hi", {32'h0, hi}, 64'hA5A5A5A5);
    valid_in = 1'b1; funct = FN_MTLO; rs_val = 32'h5A5A1234;
    @(negedge clk);
    valid_in = 1'b0;
    check("mtlo_idle lo", {32'h0, lo}, 64'h5A5A1234);
    check("mtlo_idle hi kept", {32'h0, hi}, 64'hA5A5A5A5);

    // MTHI while busy waits until the sequencer is idle.
    a = 32'h0000BEEF; b = 32'h00C0FFEE; x = 32'h13579BDF;
    valid_in = 1'b1; opcode = OP_RTYPE; funct = FN_MULTU; rs_val = a; rt_val = b;
    @(negedge clk);
    funct = FN_MTHI; rs_val = x;
    #1;
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("mthi_busy stall_cycles", 64'(cyc), 64'(W + 1));
    @(negedge clk);
    valid_in = 1'b0;
    e = ref_hilo(FN_MULTU, a, b);
    check("mthi_busy hi", {32'h0, hi}, {32'h0, x});
    check("mthi_busy lo", {32'h0, lo}, {32'h0, e[31:0]});

    // Randomized multiply/divide against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      fn = fns[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 9);
        3: begin a = $urandom_range(0, 255); b = 32'hFFFFFFFF - $urandom_range(0, 5); end
        default: ;
      endcase
      run_md($sformatf("rand%0d", i), fn, a, b, 1'b0);
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    valid_in = 1'b1; opcode = OP_RTYPE; funct = FN_MULT; rs_val = 32'h7; rt_val = 32'h9;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset busy", {63'h0, busy}, 64'h0);
    check("async_reset hi", {32'h0, hi}, 64'h0);
    check("async_reset lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_md("post_reset", FN_DIVU, 32'hDEADBEEF, 32'h00000010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
